// File: rtl/harmonic_sequencer.sv
// Per-sample sequencer for the additive-synthesis datapath: sample-rate timer,
// control shadow registers and the harmonic handshake state machine.
module harmonic_sequencer #(
  parameter logic [15:0] SAMPLE_INTERVAL = 16'd1023,
  parameter logic [7:0]  MAX_HARMONICS   = 8'd100,
  parameter logic [7:0]  TIMEOUT         = 8'd64,
  parameter logic [15:0] DEF_FREQUENCY   = 16'd90
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Ctrl_Valid,
  input  logic [15:0] i_Frequency,
  input  logic [15:0] i_Freq_Offset,
  input  logic [7:0]  i_Harmonic_Count,
  input  logic        i_Clear_Status,
  input  logic [1:0]  i_Scaler_Ready,
  input  logic        i_Sample_Ready,
  input  logic [1:0]  i_Adder_Done,
  input  logic        i_Freq_Too_High,
  output logic [15:0] o_Frequency,
  output logic [15:0] o_Freq_Offset,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [1:0]  o_Scaler_Start,
  output logic        o_Scaler_Restart,
  output logic [1:0]  o_Adder_Start,
  output logic        o_Last_Harmonic,
  output logic        o_Adder_Clear,
  output logic        o_Capture,
  output logic        o_DAC_Send,
  output logic        o_Overrun,
  output logic        o_Fault
);

  typedef enum logic [3:0] {
    S_WAIT_TICK,
    S_MULT,
    S_MULT_WAIT,
    S_SAMPLE_WAIT,
    S_ADD,
    S_ADD_WAIT,
    S_NEXT,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] freq_sh_q, freq_sh_d;
  logic [15:0] offset_sh_q, offset_sh_d;
  logic [7:0]  count_sh_q, count_sh_d;
  logic [15:0] freq_q, freq_d;
  logic [15:0] offset_q, offset_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  harmonic_q, harmonic_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        next_sample_q, next_sample_d;
  logic [1:0]  scaler_start_q, scaler_start_d;
  logic        scaler_restart_q, scaler_restart_d;
  logic [1:0]  adder_start_q, adder_start_d;
  logic        last_harmonic_q, last_harmonic_d;
  logic        adder_clear_q, adder_clear_d;
  logic        capture_q, capture_d;
  logic        dac_send_q, dac_send_d;
  logic        overrun_q, overrun_d;
  logic        fault_q, fault_d;

  logic        tick;
  logic        bank;
  logic        wait_expired;
  logic        set_overrun;
  logic        set_fault;
  logic [7:0]  count_clamped;
  logic [8:0]  harmonic_inc;

  assign tick         = (timer_q == SAMPLE_INTERVAL);
  assign bank         = harmonic_q[0];
  assign wait_expired = (wait_cnt_q == TIMEOUT - 8'd1);
  assign harmonic_inc = {1'b0, harmonic_q} + 9'd1;

  always_comb begin
    count_clamped = i_Harmonic_Count;
    if (i_Harmonic_Count == 8'd0) begin
      count_clamped = 8'd1;
    end else if (i_Harmonic_Count > MAX_HARMONICS) begin
      count_clamped = MAX_HARMONICS;
    end
  end

  // Shadows follow every control pulse; the active copies move only at an accepted tick.
  always_comb begin
    timer_d     = tick ? 16'd0 : timer_q + 16'd1;
    freq_sh_d   = i_Ctrl_Valid ? i_Frequency   : freq_sh_q;
    offset_sh_d = i_Ctrl_Valid ? i_Freq_Offset : offset_sh_q;
    count_sh_d  = i_Ctrl_Valid ? count_clamped : count_sh_q;
  end

  always_comb begin
    state_d          = state_q;
    freq_d           = freq_q;
    offset_d         = offset_q;
    count_d          = count_q;
    harmonic_d       = harmonic_q;
    wait_cnt_d       = 8'd0;
    next_sample_d    = 1'b0;
    scaler_start_d   = 2'b00;
    scaler_restart_d = 1'b0;
    adder_start_d    = 2'b00;
    last_harmonic_d  = 1'b0;
    adder_clear_d    = 1'b0;
    capture_d        = 1'b0;
    dac_send_d       = 1'b0;
    set_fault        = 1'b0;
    set_overrun      = tick && (state_q != S_WAIT_TICK);

    case (state_q)
      S_WAIT_TICK: begin
        if (tick) begin
          dac_send_d       = 1'b1;
          scaler_restart_d = 1'b1;
          next_sample_d    = 1'b1;
          harmonic_d       = 8'd0;
          freq_d           = freq_sh_q;
          offset_d         = offset_sh_q;
          count_d          = count_sh_q;
          state_d          = S_MULT;
        end
      end
      S_MULT: begin
        scaler_start_d[bank] = 1'b1;
        state_d              = S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        if (i_Scaler_Ready[bank]) begin
          state_d = S_SAMPLE_WAIT;
        end else if (wait_expired) begin
          set_fault = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_SAMPLE_WAIT: begin
        if (i_Sample_Ready) begin
          state_d = S_ADD;
        end else if (wait_expired) begin
          set_fault = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ADD: begin
        adder_start_d[bank] = 1'b1;
        last_harmonic_d     = (harmonic_q == count_q - 8'd1);
        state_d             = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (i_Adder_Done[bank]) begin
          state_d = S_NEXT;
        end else if (wait_expired) begin
          set_fault = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_NEXT: begin
        harmonic_d    = harmonic_inc[7:0];
        next_sample_d = 1'b1;
        if (harmonic_inc >= {1'b0, count_q} || i_Freq_Too_High) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_MULT;
        end
      end
      S_CAPTURE: begin
        capture_d = 1'b1;
        state_d   = S_CLEAR;
      end
      S_CLEAR: begin
        adder_clear_d = 1'b1;
        state_d       = S_WAIT_TICK;
      end
      default: state_d = S_WAIT_TICK;
    endcase

    // A set event on the same clock as a clear request keeps the flag set.
    overrun_d = set_overrun ? 1'b1 : (i_Clear_Status ? 1'b0 : overrun_q);
    fault_d   = set_fault   ? 1'b1 : (i_Clear_Status ? 1'b0 : fault_q);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q          <= S_WAIT_TICK;
      timer_q          <= 16'd0;
      freq_sh_q        <= DEF_FREQUENCY;
      offset_sh_q      <= 16'd0;
      count_sh_q       <= MAX_HARMONICS;
      freq_q           <= DEF_FREQUENCY;
      offset_q         <= 16'd0;
      count_q          <= MAX_HARMONICS;
      harmonic_q       <= 8'd0;
      wait_cnt_q       <= 8'd0;
      next_sample_q    <= 1'b0;
      scaler_start_q   <= 2'b00;
      scaler_restart_q <= 1'b0;
      adder_start_q    <= 2'b00;
      last_harmonic_q  <= 1'b0;
      adder_clear_q    <= 1'b0;
      capture_q        <= 1'b0;
      dac_send_q       <= 1'b0;
      overrun_q        <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      freq_sh_q        <= freq_sh_d;
      offset_sh_q      <= offset_sh_d;
      count_sh_q       <= count_sh_d;
      freq_q           <= freq_d;
      offset_q         <= offset_d;
      count_q          <= count_d;
      harmonic_q       <= harmonic_d;
      wait_cnt_q       <= wait_cnt_d;
      next_sample_q    <= next_sample_d;
      scaler_start_q   <= scaler_start_d;
      scaler_restart_q <= scaler_restart_d;
      adder_start_q    <= adder_start_d;
      last_harmonic_q  <= last_harmonic_d;
      adder_clear_q    <= adder_clear_d;
      capture_q        <= capture_d;
      dac_send_q       <= dac_send_d;
      overrun_q        <= overrun_d;
      fault_q          <= fault_d;
    end
  end

  assign o_Frequency      = freq_q;
  assign o_Freq_Offset    = offset_q;
  assign o_Harmonic       = harmonic_q;
  assign o_Next_Sample    = next_sample_q;
  assign o_Scaler_Start   = scaler_start_q;
  assign o_Scaler_Restart = scaler_restart_q;
  assign o_Adder_Start    = adder_start_q;
  assign o_Last_Harmonic  = last_harmonic_q;
  assign o_Adder_Clear    = adder_clear_q;
  assign o_Capture        = capture_q;
  assign o_DAC_Send       = dac_send_q;
  assign o_Overrun        = overrun_q;
  assign o_Fault          = fault_q;

endmodule
